// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA frame-buffer write engine.
// Register offsets, frame geometry, engine states and STATUS bit positions.
package vga_fb_pkg;

    localparam logic [1:0] REG_PTR    = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_FILL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int FB_PIXELS    = 307200;
    localparam int PIX_PER_WORD = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2
    } fb_state_t;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_LEVEL = 4;
    localparam int ST_WRAP  = 8;

endpackage

// File: rtl/vga_fb_fifo.sv
// Small synchronous show-ahead FIFO holding packed pixel words.
// Latency: pushed word visible on pop_dat the next cycle; push ignored when full, pop ignored when empty.
module vga_fb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/vga_fb_writer.sv
// Wishbone slave that serialises packed pixel words and fill runs into frame-buffer port A.
// Latency: DATA accepted at N -> ack N+1, first fb_we N+2; one pixel per clock thereafter.
// Backpressure: ack withheld for DATA while FIFO full, and for PTR/FILL while engine busy.
module vga_fb_writer #(
    parameter int ADDR_W     = 19,
    parameter int PIX_W      = 4,
    parameter int FB_PIXELS  = 307200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic [5:0]        i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_rdt,
    output logic              o_wb_ack,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_din
);
    import vga_fb_pkg::*;

    localparam int                LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FB_PIXELS - 1);

    fb_state_t         state, state_nxt;
    logic [31:0]       shreg, shreg_nxt, fifo_dout, rd_val, status;
    logic [2:0]        pix_idx, pix_idx_nxt;
    logic [ADDR_W-1:0] ptr, fill_cnt, fill_cnt_nxt;
    logic [PIX_W-1:0]  fill_col, emit_pix;
    logic [LVL_W-1:0]  fifo_level;
    logic [1:0]        reg_sel;
    logic              fifo_full, fifo_empty, busy, req, reg_ok, accept, wr;
    logic              push, pop, emit, fill_go, wrap_set, wrap_clr, wrap_flag;
    logic              unused_bits;

    assign unused_bits = ^{i_wb_sel, i_wb_adr[5:4], i_wb_adr[1:0]};

    vga_fb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk      (wb_clk),
        .rst_n    (wb_rst_n),
        .push     (push),
        .push_dat (i_wb_dat),
        .pop      (pop),
        .pop_dat  (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign reg_sel = i_wb_adr[3:2];
    assign busy    = (state != IDLE) || !fifo_empty;
    // Masking with ack keeps a held strobe from being accepted twice.
    assign req     = i_wb_cyc & i_wb_stb & ~o_wb_ack;

    always_comb begin
        reg_ok = 1'b1;
        if (i_wb_we) begin
            case (reg_sel)
                REG_DATA:   reg_ok = !fifo_full;
                REG_STATUS: reg_ok = 1'b1;
                default:    reg_ok = !busy;
            endcase
        end
    end

    assign accept   = req & reg_ok;
    assign wr       = accept & i_wb_we;
    assign push     = wr && (reg_sel == REG_DATA);
    assign fill_go  = wr && (reg_sel == REG_FILL) && (i_wb_dat[ADDR_W-1:0] != '0);
    assign wrap_set = emit && (ptr == LAST_PIX);
    assign wrap_clr = wr && (reg_sel == REG_STATUS) && i_wb_dat[ST_WRAP];

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        pix_idx_nxt  = pix_idx;
        fill_cnt_nxt = fill_cnt;
        emit         = 1'b0;
        pop          = 1'b0;
        emit_pix     = fill_col;
        case (state)
            IDLE: begin
                // Pixel 0 goes straight from the FIFO head to meet the N+2 write latency.
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    emit        = 1'b1;
                    emit_pix    = fifo_dout[PIX_W-1:0];
                    shreg_nxt   = fifo_dout;
                    pix_idx_nxt = 3'd1;
                    state_nxt   = DRAIN;
                end else if (fill_go) begin
                    fill_cnt_nxt = i_wb_dat[ADDR_W-1:0];
                    state_nxt    = FILL;
                end
            end
            DRAIN: begin
                emit        = 1'b1;
                emit_pix    = shreg[pix_idx*PIX_W +: PIX_W];
                pix_idx_nxt = pix_idx + 3'd1;
                if (pix_idx == 3'd7) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shreg_nxt = fifo_dout;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            FILL: begin
                emit         = 1'b1;
                fill_cnt_nxt = fill_cnt - 1'b1;
                if (fill_cnt == ADDR_W'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        status                     = '0;
        status[ST_BUSY]            = busy;
        status[ST_FULL]            = fifo_full;
        status[ST_EMPTY]           = fifo_empty;
        status[ST_LEVEL +: LVL_W]  = fifo_level;
        status[ST_WRAP]            = wrap_flag;
        case (reg_sel)
            REG_PTR:    rd_val = 32'(ptr);
            REG_FILL:   rd_val = 32'(fill_cnt);
            REG_STATUS: rd_val = status;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            pix_idx   <= '0;
            fill_cnt  <= '0;
            fill_col  <= '0;
            ptr       <= '0;
            wrap_flag <= 1'b0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_din    <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_rdt  <= '0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            pix_idx  <= pix_idx_nxt;
            fill_cnt <= fill_cnt_nxt;
            if (fill_go) fill_col <= i_wb_dat[24 +: PIX_W];

            if (emit)
                ptr <= (ptr == LAST_PIX) ? '0 : ptr + 1'b1;
            else if (wr && (reg_sel == REG_PTR))
                ptr <= (i_wb_dat[ADDR_W-1:0] > LAST_PIX) ? '0 : i_wb_dat[ADDR_W-1:0];

            // A wrap in the same cycle as a clear leaves the flag set.
            if (wrap_set)      wrap_flag <= 1'b1;
            else if (wrap_clr) wrap_flag <= 1'b0;

            fb_we <= emit;
            if (emit) begin
                fb_addr <= ptr;
                fb_din  <= emit_pix;
            end

            o_wb_ack <= accept;
            o_wb_rdt <= (accept && !i_wb_we) ? rd_val : '0;
        end
    end

endmodule
